// File: rtl/sum_sq.sv
`default_nettype none
// ============================================================================
// Module   : sum_sq
// Brief    : Sequential y = a*a + b*b, one shift-add partial product per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sum_sq #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2 * IN_W + 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [IN_W-1:0]  a_bi,
    input  logic [IN_W-1:0]  b_bi,
    output logic [OUT_W-1:0] y_bo,
    output logic             busy_o,
    output logic             done_o
);

    localparam int             c_CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQ_A = 2'd1,
        S_SQ_B = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IN_W-1:0]     r_a;
    logic [IN_W-1:0]     r_b;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [OUT_W-1:0]    r_acc;
    logic [OUT_W-1:0]    r_y;
    logic                r_done;

    logic [IN_W-1:0]     w_op;
    logic                w_bit;
    logic                w_last;
    logic [OUT_W-1:0]    w_addend;

    // Squaring x is sum over set bits x[i] of (x << i), so the same operand
    // serves as both multiplier and multiplicand.
    assign w_op     = (r_state == S_SQ_A) ? r_a : r_b;
    assign w_bit    = w_op[r_cnt];
    assign w_last   = (r_cnt == c_LAST);
    assign w_addend = {{(OUT_W-IN_W){1'b0}}, w_op} << r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_SQ_A;
            S_SQ_A: if (w_last)  w_next = S_SQ_B;
            S_SQ_B: if (w_last)  w_next = S_FIN;
            S_FIN:               w_next = S_IDLE;
            default:             w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a   <= a_bi;
                        r_b   <= b_bi;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SQ_A, S_SQ_B: begin
                    if (w_bit) r_acc <= r_acc + w_addend;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                S_FIN: begin
                    r_y    <= r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign y_bo   = r_y;
    assign done_o = r_done;
    assign busy_o = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sum_sq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_sq
// Brief    : Directed and randomized checks of sum_sq against a + arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sum_sq;

    localparam int IN_W  = 8;
    localparam int OUT_W = 2 * IN_W + 2;
    localparam int c_LAT = 2 * IN_W + 1;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic [IN_W-1:0]  a_bi;
    logic [IN_W-1:0]  b_bi;
    logic [OUT_W-1:0] y_bo;
    logic             busy_o;
    logic             done_o;

    int vectors;
    int miscompares;

    sum_sq #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .y_bo    (y_bo),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int model(input int a, input int b);
        return a * a + b * b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === exp[31:0]) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Waits for done_o; n0 edges since the accepting edge have already passed.
    task automatic wait_done(input string tag, input int exp_y, input int n0);
        int n;
        bit busy_ok;
        n = n0;
        busy_ok = 1'b1;
        while (done_o !== 1'b1 && n < 100) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            step();
            n++;
        end
        chk({tag, "_latency"}, n, c_LAT);
        chk({tag, "_busy_held"}, busy_ok, 1);
        chk({tag, "_y"}, y_bo, exp_y);
        chk({tag, "_busy_at_done"}, busy_o, 0);
    endtask

    task automatic launch(input string tag, input int a, input int b);
        a_bi    = IN_W'(a);
        b_bi    = IN_W'(b);
        start_i = 1'b1;
        step();
        chk({tag, "_accept"}, busy_o, 1);
        start_i = 1'b0;
        a_bi    = IN_W'($urandom);
        b_bi    = IN_W'($urandom);
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        launch(tag, a, b);
        wait_done(tag, model(a, b), 0);
        step();
        chk({tag, "_done_drop"}, done_o, 0);
    endtask

    initial begin
        int seen;
        int ra, rb;
        vectors     = 0;
        miscompares = 0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        a_bi    = '0;
        b_bi    = '0;
        step();
        step();
        chk("rst_y", y_bo, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_i = 1'b0;
        step();
        chk("idle_busy", busy_o, 0);

        run_op("t1", 3, 4);
        run_op("t2_max", 255, 255);
        run_op("t2_zero", 0, 0);
        run_op("t2_azero", 0, 200);
        run_op("t6_mag", 6, 8);

        // Start while busy must be ignored and operands not re-latched.
        launch("t3", 3, 4);
        repeat (4) step();
        a_bi    = 8'd9;
        b_bi    = 8'd9;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done("t3", model(3, 4), 5);
        step();

        // Asynchronous reset inside SQ_B, between clock edges.
        launch("t4", 200, 100);
        repeat (12) step();
        #3;
        rst_i = 1'b1;
        #1;
        chk("t4_rst_busy", busy_o, 0);
        chk("t4_rst_done", done_o, 0);
        chk("t4_rst_y", y_bo, 0);
        step();
        rst_i = 1'b0;
        seen = 0;
        repeat (25) begin
            step();
            if (done_o === 1'b1 || busy_o === 1'b1) seen++;
        end
        chk("t4_no_done", seen, 0);

        // start_i held high: each done cycle accepts the next pair.
        a_bi    = 8'd1;
        b_bi    = 8'd1;
        start_i = 1'b1;
        step();
        chk("t5_accept0", busy_o, 1);
        a_bi = 8'd12;
        b_bi = 8'd5;
        wait_done("t5_p0", 2, 0);
        step();
        chk("t5_accept1", busy_o, 1);
        chk("t5_done_drop1", done_o, 0);
        a_bi = 8'd255;
        b_bi = 8'd0;
        wait_done("t5_p1", 169, 0);
        step();
        chk("t5_accept2", busy_o, 1);
        start_i = 1'b0;
        a_bi    = 8'd7;
        b_bi    = 8'd7;
        wait_done("t5_p2", 65025, 0);
        step();
        chk("t5_idle", busy_o, 0);

        for (int i = 0; i < 10; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            run_op("rand", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
